apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 4, meaning APB address width in bits.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, meaning APB data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles with PREADY low before abort (range 2..255).
REQ-004 PCLK  input  1  single clock; every register is on its rising edge.
REQ-005 PRESET  input  1  reset; synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 means write, 0 means read.
REQ-009 cmd_addr  input  APB_ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  input  APB_DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response held in the one-deep response slot.
REQ-012 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  output  APB_DATA_WIDTH  read data; 0 for writes and for errors.
REQ-014 rsp_err  output  1  PSLVERR, timeout or misaligned address.
REQ-015 rsp_timeout  output  1  error cause was a timeout.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB3 requester controls.
REQ-017 PADDR  output  APB_ADDR_WIDTH, PWDATA  output  APB_DATA_WIDTH  APB3 requester address and write data.
REQ-018 PRDATA  input  APB_DATA_WIDTH, PREADY  input  1, PSLVERR  input  1  APB3 completer responses.

Function
REQ-019 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> IDLE, one transfer at a time.
REQ-020 cmd_ready SHALL be combinational: (state==IDLE) & ~rsp_valid.
REQ-021 On acceptance in cycle T with cmd_addr[1:0]==0: cycle T+1 is SETUP (PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA registered from the command); cycle T+2 is ACCESS (PSEL=1, PENABLE=1).
REQ-022 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-023 In ACCESS, PREADY=1 SHALL complete the transfer:
- PRDATA (reads only) and PSLVERR are captured into the response slot.
- rsp_valid=1 and PSEL=PENABLE=0 from the next cycle; the FSM returns to IDLE.
- Minimum latency is accept to rsp_valid = 3 cycles.
REQ-024 In ACCESS, PREADY=0 SHALL hold ACCESS and increment a wait counter.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES, the transfer SHALL abort: PSEL=PENABLE=0 next cycle; response rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 The wait counter SHALL clear on entry to SETUP.
REQ-027 PRDATA and PSLVERR SHALL be ignored unless PSEL & PENABLE & PREADY.
REQ-028 If PSLVERR=1 on completion, the response SHALL be rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-029 A command with cmd_addr[1:0]!=0 SHALL NOT start an APB transfer; next cycle rsp_valid=1, rsp_err=1, rsp_timeout=0.
REQ-030 The response slot SHALL hold all rsp_* outputs stable until rsp_ready; rsp_valid SHALL clear the cycle after the handshake.
REQ-031 A new command SHALL NOT be accepted in the same cycle as the rsp_ready handshake: back-to-back throughput is 1 transfer per 4 cycles with rsp_ready tied high.
REQ-032 PSEL SHALL never be high in IDLE, and PENABLE SHALL never be high without PSEL.

Reset
REQ-033 PRESET=1 at a rising edge SHALL force, regardless of state (including mid-transfer):
- state=IDLE; PSEL, PENABLE, PWRITE, PADDR and PWDATA = 0.
- rsp_valid, rsp_err, rsp_timeout and rsp_rdata = 0; wait counter = 0.
- No response SHALL be produced for an aborted transfer.
REQ-034 cmd_ready SHALL be 0 while PRESET=1.

Structure
REQ-035 Package apb_pkg SHALL hold the FSM state encoding (IDLE, SETUP, ACCESS), default widths and the timeout default.
REQ-036 Sub-module apb_wait_timer SHALL be used for the wait counter (clear, enable, expired).

Verification
REQ-037 Write 0x4, data 0xDEADBEEF, PREADY=1: PSEL rises at T+1, PENABLE at T+2, rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0.
REQ-038 Read 0x0, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678: rsp_rdata=0x12345678, rsp_valid at T+6.
REQ-039 Read 0x8, PREADY never high, TIMEOUT_CYCLES=16: abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1.
REQ-040 Write 0xC completing with PSLVERR=1: rsp_err=1, rsp_timeout=0; rsp_ready held low 5 cycles keeps the response stable and cmd_ready=0.
REQ-041 Command to address 0x2: no PSEL pulse; error response next cycle.
REQ-042 PRESET asserted during ACCESS: next cycle all APB outputs are 0, rsp_valid=0, cmd_ready=1 after PRESET falls.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB3 requester bridge.
package apb_pkg;

  localparam int unsigned DefAddrWidth     = 4;
  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefTimeoutCycles = 16;
  localparam int unsigned TimerWidth       = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_o flags the wait that reaches Limit.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned Limit = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TimerWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TimerWidth'(1);
    end
  end

  // Fires on the wait cycle that would bring the count up to Limit.
  assign expired_o = en_i && (cnt_q == TimerWidth'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB3 requester bridge: one transfer at a time, one-deep response slot,
// misaligned-address rejection and a PREADY wait timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned APB_DATA_WIDTH = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      timer_clr, timer_en, timer_expired;

  assign cmd_ready = (state_q == StIdle) && !rsp_valid_q && !PRESET;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_addr[1:0] != 2'b00) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d   = StSetup;
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_wdata;
            timer_clr = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d       = StIdle;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= StIdle;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  apb_wait_timer #(
    .Limit(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  assign PSEL        = (state_q != StIdle);
  assign PENABLE     = (state_q == StAccess);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with default parameters.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", rsp_valid, 0);
  endtask

  initial begin
    int n_acc;
    int gap;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    PRESET = 1'b0;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write 0x4, zero-wait; PRDATA garbage must not reach rsp_rdata.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEADBEEF;
    PREADY = 1'b1; PRDATA = 32'hFFFFFFFF;
    chk("w_accept_ready", cmd_ready, 1);
    step();                                   // T+1
    cmd_valid = 1'b0;
    chk("w_setup_psel", PSEL, 1);
    chk("w_setup_penable", PENABLE, 0);
    chk("w_setup_paddr", PADDR, 32'h4);
    chk("w_setup_pwrite", PWRITE, 1);
    chk("w_setup_pwdata", PWDATA, 32'hDEADBEEF);
    step();                                   // T+2
    chk("w_access_penable", PENABLE, 1);
    chk("w_access_rsp_valid", rsp_valid, 0);
    step();                                   // T+3
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_err", rsp_err, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_done_psel", PSEL, 0);
    handshake();

    // Read 0x0 with three wait cycles.
    PREADY = 1'b0; PRDATA = 32'hCAFE0000; PSLVERR = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0;
    step();                                   // T+1
    cmd_valid = 1'b0;
    step();                                   // T+2
    step();                                   // T+3
    step();                                   // T+4
    chk("r_wait_paddr", PADDR, 0);
    chk("r_wait_penable", PENABLE, 1);
    step();                                   // T+5
    PREADY = 1'b1; PRDATA = 32'h12345678; PSLVERR = 1'b0;
    chk("r_wait_rsp_valid", rsp_valid, 0);
    step();                                   // T+6
    PREADY = 1'b0;
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r_rsp_err", rsp_err, 0);
    handshake();

    // Read 0x8 never ready: timeout after 16 ACCESS cycles.
    PRDATA = 32'hAAAA5555; PSLVERR = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 4'h8;
    step();                                   // T+1
    cmd_valid = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (PENABLE !== 1'b1) break;
      n_acc++;
    end
    chk("to_access_cycles", n_acc, 16);
    chk("to_psel", PSEL, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    handshake();

    // Write 0xC with PSLVERR; response held while rsp_ready is low.
    PSLVERR = 1'b1; PREADY = 1'b1; PRDATA = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h00C0FFEE;
    step();
    cmd_valid = 1'b0;
    step();
    step();                                   // T+3
    cmd_valid = 1'b1; cmd_addr = 4'h4;        // must not be taken while response pending
    for (int i = 0; i < 5; i++) begin
      chk("se_hold_valid", rsp_valid, 1);
      chk("se_hold_err", rsp_err, 1);
      chk("se_hold_timeout", rsp_timeout, 0);
      chk("se_hold_cmd_ready", cmd_ready, 0);
      chk("se_hold_psel", PSEL, 0);
      step();
    end
    cmd_valid = 1'b0; PSLVERR = 1'b0;
    handshake();

    // Misaligned address 0x2: no APB transfer, error next cycle.
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
    step();
    cmd_valid = 1'b0;
    chk("mis_psel", PSEL, 0);
    chk("mis_rsp_valid", rsp_valid, 1);
    chk("mis_rsp_err", rsp_err, 1);
    chk("mis_rsp_timeout", rsp_timeout, 0);
    handshake();

    // Back-to-back with rsp_ready high: next acceptance 4 cycles later.
    rsp_ready = 1'b1; PREADY = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h1;
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cmd_ready === 1'b1) begin
        gap = i;
        break;
      end
    end
    chk("b2b_gap", gap, 4);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rsp_ready = 1'b0;
    chk("b2b_drained", rsp_valid, 0);

    // Reset during ACCESS.
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h5A5A5A5A;
    step();
    cmd_valid = 1'b0;
    step();                                   // T+2 ACCESS
    chk("rr_in_access", PENABLE, 1);
    PRESET = 1'b1; PREADY = 1'b1;
    step();
    chk("rr_psel", PSEL, 0);
    chk("rr_penable", PENABLE, 0);
    chk("rr_pwrite", PWRITE, 0);
    chk("rr_paddr", PADDR, 0);
    chk("rr_pwdata", PWDATA, 0);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_cmd_ready", cmd_ready, 0);
    PRESET = 1'b0;
    step();
    chk("rr_after_cmd_ready", cmd_ready, 1);
    chk("rr_after_rsp_valid", rsp_valid, 0);
    step();
    chk("rr_no_late_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
